gray2bin_rr_scheduler: RTL
==========================

Name: gray2bin_rr_scheduler

Overview:
Shares one serial Gray-to-binary conversion datapath among NUM_REQ requesters.
A round-robin arbiter grants one requester at a time and latches its Gray word. The word is converted MSB-first, one bit per clock. The binary result and the requester ID are then presented on a valid/ready output port.
Sits between multiple Gray-coded sources (pointers, encoder counts) and binary consumers that cannot each afford a converter.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 4, Gray/binary word width in bits (>=2)
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  NUM_REQ  per-requester request valid
req_gray  input  NUM_REQ*WIDTH  flattened Gray words; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready  output  NUM_REQ  one-hot accept strobe; combinational
out_valid  output  1  result valid
out_data  output  WIDTH  binary result
out_id  output  ID_W  index of the requester that owns out_data
out_ready  input  1  consumer accepts the result
busy  output  1  high in CONVERT or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - out_valid=0, out_data=0, out_id=0, busy=0.
  - Bit counter = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Applies from any state. An in-flight conversion is discarded and never produces out_valid.
- FSM state IDLE:
  - Scan req_valid starting at (last_grant+1) mod NUM_REQ, wrapping; the first set bit wins.
  - req_ready[win]=1 combinationally in the same cycle; all other bits 0.
  - If no req_valid bit is set, req_ready=0.
  - Accept edge (req_valid[win] & req_ready[win]): latch req_gray[win] into the shift register, out_id<=win, last_grant<=win, counter<=WIDTH-1, go to CONVERT.
  - last_grant changes only on an accept edge.
- FSM state CONVERT:
  - req_ready=0.
  - Each edge computes one bit: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for the bit at counter; counter decrements.
  - After the edge that computes bit 0 (WIDTH edges in CONVERT), go to DONE and set out_valid=1.
- FSM state DONE:
  - out_valid=1; out_data and out_id are held stable; req_ready=0.
  - An edge with out_ready=1 completes the transfer: out_valid<=0, go to IDLE.
  - out_ready low holds DONE indefinitely.
- Latency and throughput:
  - out_valid rises exactly WIDTH edges after the accept edge.
  - Minimum period between successive accepts is WIDTH+2 cycles: 1 IDLE, WIDTH CONVERT, 1 DONE with out_ready=1.
  - IDLE never accepts in the same cycle DONE completes.
- Requester rules:
  - A requester holds req_valid and req_gray until it sees req_ready.
  - Dropping req_valid without a handshake is legal and simply removes it from arbitration.
  - req_gray of non-granted requesters is ignored.
- busy = (state!=IDLE).
- out_data is never partially updated while out_valid=1.
- Unknown/illegal state encodings return to IDLE on the next edge.

Test Plan:
(all with NUM_REQ=4, WIDTH=4)
1. After reset, req_valid=4'b0100, gray 4'b1101 on ch2 -> req_ready=4'b0100 in the request cycle; out_valid 4 edges after accept; out_data=4'b1001, out_id=2.
2. Sweep gray 0..15 on ch0 with out_ready=1 -> out_data equals the binary of each input, e.g. 1000->1111, 0110->0100, 1111->1010. Successive accepts are exactly 6 cycles apart.
3. All four req_valid held high from reset -> grant order 0,1,2,3,0,1 and out_id follows the same order.
4. out_ready=0 for 5 cycles in DONE -> out_valid, out_data and out_id stay constant; req_ready=0 throughout; on out_ready=1, one transfer then IDLE.
5. rst_n=0 after two CONVERT edges -> next cycle out_valid=0 and busy=0. Next request with all four valid is granted to ch0.
6. last_grant=1, req_valid=4'b1010 simultaneously -> ch3 granted first, then ch1 on its next IDLE.

Source files
------------

// File: rtl/gray2bin_rr_scheduler.sv
// Round-robin arbiter in front of one shared bit-serial Gray-to-binary converter.
// Results leave on a valid/ready port tagged with the owning requester's index.
module gray2bin_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_gray,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [ID_W-1:0]            out_id,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic               prev;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    win;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic               bit_val;

    // Scan starts one past the last winner so every requester gets a turn.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
        grant = found ? (NUM_REQ'(1) << win) : '0;
    end

    assign req_ready = (state == IDLE) ? grant : '0;
    assign busy      = (state != IDLE);

    // sreg shifts MSB-first; prev carries the previously produced binary bit.
    assign bit_val = sreg[WIDTH-1] ^ prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            cnt        <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            sreg       <= '0;
            prev       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sreg       <= req_gray[int'(win)*WIDTH +: WIDTH];
                        out_id     <= win;
                        last_grant <= win;
                        cnt        <= CNT_W'(WIDTH - 1);
                        prev       <= 1'b0;
                        state      <= CONVERT;
                    end
                end
                CONVERT: begin
                    // out_valid is low here, so shifting straight into out_data is safe.
                    sreg     <= sreg << 1;
                    prev     <= bit_val;
                    out_data <= {out_data[WIDTH-2:0], bit_val};
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
